// File: rtl/led_flow_sequencer.sv
// led_flow_sequencer: moving one-hot head for the flow LED mode, with prescaler, step rate, direction and restart.
// Optional ping-pong motion is compiled in with `define LED_FLOW_BOUNCE_EN.
module led_flow_sequencer #(
  parameter int LED_NUM   = 8,
  parameter int TICK_DIV  = 12000,
  parameter int STEP_BASE = 50
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               dir,
  input  logic [1:0]         speed,
  input  logic               restart,
  input  logic               bounce,
  output logic [LED_NUM-1:0] led_select,
  output logic [3:0]         pos,
  output logic               step
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(STEP_BASE * 4 + 1);
  localparam logic [3:0] LAST = 4'(LED_NUM - 1);
  typedef enum logic {FWD, REV} state_t;
  state_t st, st_nxt;
  logic [PW-1:0] pre;
  logic [SW-1:0] scnt, lim;
  logic tick, do_step, bnc, fwd_end, rev_end;
  logic [3:0] pos_nxt;
  assign tick = enable && pre == PW'(TICK_DIV - 1);
  assign lim = SW'(STEP_BASE) * (SW'(speed) + SW'(1)) - SW'(1);
  assign do_step = tick && scnt >= lim;
`ifdef LED_FLOW_BOUNCE_EN
  assign bnc = bounce;
  assign fwd_end = bounce && st == FWD && pos == LAST;
  assign rev_end = bounce && st == REV && pos == 4'd0;
`else
  logic unused_bounce;
  assign unused_bounce = bounce;
  assign bnc = 1'b0;
  assign fwd_end = 1'b0;
  assign rev_end = 1'b0;
`endif
  // Bounce mode keeps its own state and flips it only when a step hits an end.
  always_comb begin
    st_nxt = !bnc ? state_t'(dir) : (do_step && fwd_end) ? REV : (do_step && rev_end) ? FWD : st;
    pos_nxt = fwd_end ? LAST - 4'd1 :
              rev_end ? 4'd1 :
              st == FWD ? (pos == LAST ? 4'd0 : pos + 4'd1) :
                          (pos == 4'd0 ? LAST : pos - 4'd1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre        <= '0;
      scnt       <= '0;
      st         <= FWD;
      pos        <= 4'd0;
      led_select <= LED_NUM'(1);
      step       <= 1'b0;
    end else if (restart) begin
      pre        <= '0;
      scnt       <= '0;
      st         <= state_t'(dir);
      pos        <= dir ? LAST : 4'd0;
      led_select <= dir ? LED_NUM'(1) << LAST : LED_NUM'(1);
      step       <= 1'b0;
    end else if (enable) begin
      pre  <= tick ? '0 : pre + PW'(1);
      scnt <= do_step ? '0 : tick ? scnt + SW'(1) : scnt;
      st   <= st_nxt;
      step <= do_step;
      if (do_step) begin
        pos        <= pos_nxt;
        led_select <= LED_NUM'(1) << pos_nxt;
      end
    end else begin
      step <= 1'b0;
    end
  end
endmodule

// File: tb/tb_led_flow_sequencer.sv
// tb_led_flow_sequencer: directed plus randomized checks of led_flow_sequencer against a cycle-level reference model.
// Build with or without `define LED_FLOW_BOUNCE_EN; the model follows the same macro.
module tb_led_flow_sequencer;
  localparam int N = 8, TD = 4, SB = 2;
  logic clk, rst, enable, dir, restart, bounce, step;
  logic [1:0] speed;
  logic [N-1:0] led_select;
  logic [3:0] pos;
  int tests = 0, fails = 0;
  int ecyc, tks, m_pos;
  bit m_fwd, m_step;
`ifdef LED_FLOW_BOUNCE_EN
  int bexp[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 1};
  localparam bit BEN = 1'b1;
`else
  int bexp[9] = '{7, 0, 1, 2, 3, 4, 5, 6, 7};
  localparam bit BEN = 1'b0;
`endif

  led_flow_sequencer #(.LED_NUM(N), .TICK_DIV(TD), .STEP_BASE(SB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .dir(dir), .speed(speed),
    .restart(restart), .bounce(bounce), .led_select(led_select), .pos(pos), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    ecyc = 0; tks = 0; m_fwd = 1'b1; m_pos = 0; m_step = 1'b0;
  endtask

  // One clock edge: ticks every TD enabled cycles, a step once enough ticks have gathered for the current speed.
  task automatic model_edge();
    bit bon;
    bon = BEN && bounce;
    m_step = 1'b0;
    if (restart) begin
      ecyc = 0; tks = 0; m_fwd = !dir; m_pos = dir ? N - 1 : 0;
    end else if (enable) begin
      ecyc++;
      if (ecyc % TD == 0) begin
        tks++;
        if (tks >= SB * (int'(speed) + 1)) begin
          tks = 0; m_step = 1'b1;
          if (bon && m_fwd && m_pos == N - 1) begin m_pos = N - 2; m_fwd = 1'b0; end
          else if (bon && !m_fwd && m_pos == 0) begin m_pos = 1; m_fwd = 1'b1; end
          else m_pos = (m_pos + (m_fwd ? 1 : N - 1)) % N;
        end
      end
      if (!bon) m_fwd = !dir;
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] el;
    el = N'(1) << m_pos;
    tests++;
    assert (led_select === el) else begin fails++; $error("FAIL %s led_select got %h exp %h", tag, led_select, el); end
    tests++;
    assert (pos === 4'(m_pos)) else begin fails++; $error("FAIL %s pos got %0d exp %0d", tag, pos, m_pos); end
    tests++;
    assert (step === m_step) else begin fails++; $error("FAIL %s step got %b exp %b", tag, step, m_step); end
  endtask

  task automatic chk_pos(input string tag, input int p);
    tests++;
    assert (pos === 4'(p) && led_select === N'(1) << p) else begin
      fails++; $error("FAIL %s pos/led got %0d/%h exp %0d", tag, pos, led_select, p);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk); model_edge(); #1; check_all("cyc");
      @(negedge clk);
    end
  endtask

  task automatic wait_step(input string tag, input int exp);
    int n;
    n = 0;
    do begin n++; cyc(1); end while (!step && n < 200);
    tests++;
    assert (n === exp) else begin fails++; $error("FAIL %s step delay got %0d exp %0d", tag, n, exp); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; dir = 1'b0; speed = 2'd0; restart = 1'b0; bounce = 1'b0;
    model_reset();
    #3; check_all("reset");
    @(negedge clk); rst = 1'b0; enable = 1'b1;
    wait_step("first", 8);
    chk_pos("first_pos", 1);
    cyc(56);
    chk_pos("wrap", 0);
    dir = 1'b1;
    wait_step("rev1", 8);
    chk_pos("rev1_pos", 7);
    wait_step("rev2", 8);
    chk_pos("rev2_pos", 6);
    cyc(3);
    restart = 1'b1; cyc(1); restart = 1'b0;
    chk_pos("restart_rev", 7);
    wait_step("restart_step", 8);
    dir = 1'b0; restart = 1'b1; cyc(1); restart = 1'b0; speed = 2'd3;
    wait_step("speed3", 32);
    cyc(20); speed = 2'd0;
    wait_step("speed_drop", 4);
    wait_step("speed0", 8);
    restart = 1'b1; cyc(1); restart = 1'b0;
    cyc(3); enable = 1'b0; cyc(20); enable = 1'b1;
    wait_step("pause", 5);
    cyc(3);
    #2; rst = 1'b1; #1; model_reset(); check_all("async_rst");
    @(negedge clk); rst = 1'b0;
    wait_step("post_rst", 8);
    restart = 1'b1; cyc(1); restart = 1'b0;
    cyc(48);
    chk_pos("pre_bounce", 6);
    bounce = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wait_step("bounce_step", 8);
      chk_pos("bounce_pos", bexp[k]);
    end
    bounce = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      enable  = $urandom_range(0, 9) != 0;
      restart = $urandom_range(0, 99) == 0;
      if ($urandom_range(0, 59) == 0) dir = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 39) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) bounce = $urandom_range(0, 1) == 1;
      cyc(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
